// File: rtl/tb_ctrl.sv
// tb_ctrl -- survivor-memory / traceback controller for the K=4 Viterbi decoder.
//
// Decision vectors from the ACS array land in four DEPTH-word banks used
// round-robin. Once two banks are full, every newly completed bank launches
// one traceback: a training pass over the newest bank followed by a decode
// pass over the bank before it, both read newest-step-first. Decoded bits
// come back in reverse trellis order and are re-emitted forward on dout.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   din_valid/din       ACS decision vector for one trellis step
//   din_ready           controller accepts din this cycle
//   tbu_enable          traceback unit enable (low forces its state to 0)
//   tbu_selection       0 = training pass, 1 = decode pass
//   tbu_d_in_0/1        training / decode bank word (unused one is 0)
//   tbu_d_o/tbu_wr_en   decoded bit from the traceback unit, reverse order
//   dout/dout_valid     decoded bits, forward order, DEPTH per traceback
//   stall_cnt           (TBCTRL_STALL_CNT_EN only) saturating count of
//                       cycles with din_valid && !din_ready
module tb_ctrl #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  output logic          din_ready,
  output logic          tbu_enable,
  output logic          tbu_selection,
  output logic [DW-1:0] tbu_d_in_0,
  output logic [DW-1:0] tbu_d_in_1,
  input  logic          tbu_d_o,
  input  logic          tbu_wr_en,
  output logic          dout,
  output logic          dout_valid
`ifdef TBCTRL_STALL_CNT_EN
  ,output logic [15:0]  stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, TRAIN, DECODE} state_t;

  state_t        state;
  logic [DW-1:0] mem [4*DEPTH];
  logic [1:0]    wbank, fill, pend_train, pend_dec, cur_train, cur_dec;
  logic [AW-1:0] waddr, raddr;
  logic          pending, wr, wr_done;

  // Only stall when a second bank is waiting and the current traceback
  // still holds the banks: accepting more would overwrite the decode bank.
  assign din_ready = !(pending && state != IDLE);
  assign wr        = din_valid && din_ready;
  assign wr_done   = wr && (waddr == AW'(DEPTH-1));

  // bank storage, no reset
  always_ff @(posedge clk) begin
    if (wr) mem[{wbank, waddr}] <= din;
  end

  // write control, pending request, traceback FSM and registered read port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbank         <= '0;
      waddr         <= '0;
      fill          <= '0;
      pending       <= 1'b0;
      pend_train    <= '0;
      pend_dec      <= '0;
      cur_train     <= '0;
      cur_dec       <= '0;
      raddr         <= '0;
      state         <= IDLE;
      tbu_enable    <= 1'b0;
      tbu_selection <= 1'b0;
      tbu_d_in_0    <= '0;
      tbu_d_in_1    <= '0;
    end else begin
      if (wr) waddr <= waddr + 1'b1;  // DEPTH is a power of two: wraps itself
      if (wr_done) begin
        wbank <= wbank + 1'b1;
        if (fill != 2'd2) fill <= fill + 1'b1;
      end

      // fill reaches 2 after this completion iff it was already non-zero.
      // A new completion wins over the IDLE->TRAIN clear so it is not lost.
      if (wr_done && fill != 2'd0) begin
        pending    <= 1'b1;
        pend_train <= wbank;
        pend_dec   <= wbank - 1'b1;
      end else if (state == IDLE && pending) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: if (pending) begin
          state     <= TRAIN;
          raddr     <= AW'(DEPTH-1);
          cur_train <= pend_train;
          cur_dec   <= pend_dec;
        end
        TRAIN: begin
          raddr <= raddr - 1'b1;              // 0 -> DEPTH-1 for decode
          if (raddr == '0) state <= DECODE;
        end
        DECODE: begin
          raddr <= raddr - 1'b1;
          if (raddr == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // read data and phase flags registered together so they stay aligned
      tbu_d_in_0    <= (state == TRAIN)  ? mem[{cur_train, raddr}] : '0;
      tbu_d_in_1    <= (state == DECODE) ? mem[{cur_dec, raddr}]   : '0;
      tbu_enable    <= (state == TRAIN) || (state == DECODE);
      tbu_selection <= (state == DECODE);
    end
  end

  // capture and reorder
  logic [DEPTH-2:0] cap;
  logic [DEPTH-1:0] full, rev, out_sr;
  logic [AW-1:0]    cap_cnt, out_left;
  logic             copy;

  always_comb begin
    full = {cap, tbu_d_o};
    rev  = '0;
    // first-arrived bit is the last trellis step; put trellis step 0 at MSB
    for (int i = 0; i < DEPTH; i++) rev[i] = full[DEPTH-1-i];
  end

  assign copy = tbu_wr_en && (cap_cnt == AW'(DEPTH-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap        <= '0;
      cap_cnt    <= '0;
      out_sr     <= '0;
      out_left   <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      if (tbu_wr_en) begin
        cap     <= full[DEPTH-2:0];
        cap_cnt <= copy ? '0 : cap_cnt + 1'b1;
      end
      if (copy) begin
        dout       <= rev[DEPTH-1];
        dout_valid <= 1'b1;
        out_sr     <= {rev[DEPTH-2:0], 1'b0};
        out_left   <= AW'(DEPTH-1);
      end else if (out_left != '0) begin
        dout       <= out_sr[DEPTH-1];
        dout_valid <= 1'b1;
        out_sr     <= {out_sr[DEPTH-2:0], 1'b0};
        out_left   <= out_left - 1'b1;
      end else begin
        dout       <= 1'b0;
        dout_valid <= 1'b0;
      end
    end
  end

`ifdef TBCTRL_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                          stall_cnt <= '0;
    else if (din_valid && !din_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_tb_ctrl.sv
// Bench for tb_ctrl: plays the traceback unit (a small 3-bit state walker),
// keeps a word-level model of accepted input and predicts decoded output.
module tb_tb_ctrl;
  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_ready, tbu_enable, tbu_selection;
  logic [DW-1:0] tbu_d_in_0, tbu_d_in_1;
  logic          tbu_d_o = 1'b0, tbu_wr_en = 1'b0;
  logic          dout, dout_valid;
`ifdef TBCTRL_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  tb_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .tbu_enable(tbu_enable), .tbu_selection(tbu_selection),
    .tbu_d_in_0(tbu_d_in_0), .tbu_d_in_1(tbu_d_in_1),
    .tbu_d_o(tbu_d_o), .tbu_wr_en(tbu_wr_en),
    .dout(dout), .dout_valid(dout_valid)
`ifdef TBCTRL_STALL_CNT_EN
    ,.stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model: every accepted word in order; block n>=1 yields one traceback
  logic [DW-1:0] acc_words[$];
  logic          exp_q[$];
  int            n_valid = 0, run = 0, n_stall = 0;

  function automatic void gen_expected(input int n);
    int   s = 0;
    logic b;
    logic bits [DEPTH];
    for (int k = DEPTH-1; k >= 0; k--) begin
      b = acc_words[n*DEPTH + k][s];
      s = ((s << 1) | int'(b)) & 7;
    end
    for (int k = DEPTH-1; k >= 0; k--) begin
      bits[k] = acc_words[(n-1)*DEPTH + k][s];
      s = ((s << 1) | int'(bits[k])) & 7;
    end
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(bits[k]);
  endfunction

  function automatic void model_push(input logic [DW-1:0] d);
    acc_words.push_back(d);
    if (acc_words.size() % DEPTH == 0 && acc_words.size() >= 2*DEPTH)
      gen_expected(acc_words.size()/DEPTH - 1);
  endfunction

  // traceback unit: state walks through decision bits, cleared while disabled
  initial begin
    logic [2:0]    tbs;
    logic [DW-1:0] w;
    logic          b;
    tbs = '0;
    forever begin
      @(negedge clk);
      if (!tbu_enable) begin
        tbs = '0; tbu_wr_en = 1'b0; tbu_d_o = 1'b0;
      end else begin
        w   = tbu_selection ? tbu_d_in_1 : tbu_d_in_0;
        b   = w[tbs];
        tbs = {tbs[1:0], b};
        tbu_wr_en = tbu_selection;
        tbu_d_o   = tbu_selection & b;
      end
    end
  end

  // output monitor
  initial forever begin
    @(negedge clk);
    if (!rst) run = 0;
    else begin
      if (din_valid && !din_ready) n_stall++;
      if (dout_valid) begin
        n_valid++; run++;
        if (exp_q.size() == 0) chk("spurious_valid", dout_valid, 1'b0);
        else chk("dout", dout, exp_q.pop_front());
      end else if (run != 0) begin
        chk("run_len", run, DEPTH);
        run = 0;
      end
    end
  end

  // read-port recorder for the sequencing test
  logic        rec_en = 1'b0;
  logic [17:0] rec_q[$];
  initial forever begin
    @(negedge clk);
    if (rec_en && rst && (rec_q.size() > 0 || tbu_enable) && rec_q.size() < 2*DEPTH)
      rec_q.push_back({tbu_enable, tbu_selection, tbu_d_in_0, tbu_d_in_1});
  end

  task automatic send(input logic [DW-1:0] d);
    for (int t = 0; t < 200; t++) begin
      din_valid = 1'b1; din = d;
      @(negedge clk);
      if (din_ready) begin
        model_push(d);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    chk("ready_timeout", din_ready, 1'b1);
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    @(negedge clk); #2;
    rst = 1'b0;
    acc_words.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    n_valid = 0; n_stall = 0;
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, din_ready, 1'b1);
    chk({tag, "_en"}, tbu_enable, 1'b0);
    chk({tag, "_sel"}, tbu_selection, 1'b0);
    chk({tag, "_d0"}, tbu_d_in_0, '0);
    chk({tag, "_d1"}, tbu_d_in_1, '0);
    chk({tag, "_dout"}, dout, 1'b0);
    chk({tag, "_dv"}, dout_valid, 1'b0);
`ifdef TBCTRL_STALL_CNT_EN
    chk({tag, "_stall"}, stall_cnt, 0);
`endif
  endtask

  initial begin
    // reset values
    #2 rst = 1'b0;
    #1 chk_idle_outputs("rst");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // read sequencing 00..1F
    rec_en = 1'b1;
    for (int i = 0; i < 2*DEPTH; i++) send(8'(i));
    idle(80);
    rec_en = 1'b0;
    chk("rec_len", rec_q.size(), 2*DEPTH);
    for (int i = 0; i < 2*DEPTH && i < rec_q.size(); i++) begin
      chk("seq_en", rec_q[i][17], 1'b1);
      chk("seq_sel", rec_q[i][16], (i >= DEPTH));
      chk("seq_d0", rec_q[i][15:8], (i < DEPTH) ? 8'(8'h1F - i) : 8'h00);
      chk("seq_d1", rec_q[i][7:0], (i < DEPTH) ? 8'h00 : 8'(8'h0F - (i - DEPTH)));
    end
    chk("seq_outbits", n_valid, DEPTH);

    // all-zero and all-one decisions
    do_reset();
    for (int i = 0; i < 2*DEPTH; i++) send(8'h00);
    idle(80);
    chk("zero_cnt", n_valid, DEPTH);
    do_reset();
    for (int i = 0; i < 2*DEPTH; i++) send(8'hFF);
    idle(80);
    chk("ones_cnt", n_valid, DEPTH);

    // random words with random gaps
    do_reset();
    for (int i = 0; i < 5*DEPTH; i++) begin
      send(8'($urandom));
      if ($urandom_range(3) == 0) idle($urandom_range(4, 1));
    end
    idle(100);
    chk("rand_cnt", n_valid, 4*DEPTH);
    chk("rand_left", exp_q.size(), 0);

    // backpressure: valid held continuously
    do_reset();
    for (int i = 0; i < 4*DEPTH; i++) send(8'($urandom));
    idle(120);
    chk("bp_stalled", (n_stall > 0), 1'b1);
    chk("bp_words", acc_words.size(), 4*DEPTH);
    chk("bp_cnt", n_valid, 3*DEPTH);
    chk("bp_left", exp_q.size(), 0);
`ifdef TBCTRL_STALL_CNT_EN
    chk("bp_stall_cnt", stall_cnt, n_stall);
`endif

    // reset in the middle of a decode pass
    do_reset();
    for (int i = 0; i < 2*DEPTH; i++) send(8'($urandom));
    din_valid = 1'b0;
    begin
      int t;
      for (t = 0; t < 200; t++) begin
        @(negedge clk);
        if (tbu_enable && tbu_selection) break;
      end
      chk("decode_seen", (t < 200), 1'b1);
    end
    #2 rst = 1'b0;
    acc_words.delete(); exp_q.delete();
    #1 chk_idle_outputs("mid_rst");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    n_valid = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 2*DEPTH - 1; i++) send(8'($urandom));
    idle(80);
    chk("post_rst_quiet", n_valid, 0);
    send(8'($urandom));
    idle(80);
    chk("post_rst_cnt", n_valid, DEPTH);
    chk("post_rst_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
